booth_dot_acc: RTL and testbench

- Downstream consumer of the sequential Booth multiplier (booth_mult).
- Captures each signed product M on the multiplier's done indication and accumulates LEN consecutive products into a signed dot-product.
- Presents the completed sum on a valid/ready output handshake, with a one-entry skid so products are not lost while the output stalls.

---
 rtl/booth_pkg.sv | 37 +++
 rtl/booth_done_edge.sv | 23 ++
 rtl/booth_dot_acc.sv | 168 ++++++++++++++++
 tb/tb_booth_dot_acc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for consumers of the sequential Booth multiplier.
// The saturating add is only called when BOOTH_DOT_ACC_SAT_EN is defined.
package booth_pkg;

  // Accumulator FSM: summing products, or presenting a finished sum.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Accumulator width: the full product plus guard bits against overflow.
  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // Signed add clamped to the w-bit signed range.
  // Operands are sign-extended w-bit values, so for w <= 62 the 64-bit sum
  // itself cannot overflow.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      sat_add = hi;
    end else if (s < lo) begin
      sat_add = lo;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/booth_done_edge.sv
// Turns the multiplier's done level into a single-cycle pulse.
// The pulse fires on the rising edge of done, however long done stays high.
module booth_done_edge (
  input  logic clk,
  input  logic rst_n,    // asynchronous, active-high
  input  logic done_i,
  output logic pulse_o
);

  logic done_q;

  // Delay done by one cycle so that its rising edge can be detected.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_i;
    end
  end

  assign pulse_o = done_i & ~done_q;

endmodule

// File: rtl/booth_dot_acc.sv
// Dot-product accumulator fed by booth_mult products.
// It sums LEN consecutive products into a signed ACC_W-bit value.
// The finished sum is presented on a valid/ready output.
// A one-entry skid holds a product that arrives while the output stalls.
// Optional feature macro: BOOTH_DOT_ACC_SAT_EN. When it is defined, an
// overflowing add saturates. Otherwise the add wraps. ovf is flagged in
// both cases.
module booth_dot_acc
  import booth_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LEN   = 4,
  parameter  int GUARD = 8,
  localparam int ACC_W = acc_width(WIDTH, GUARD),
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,      // asynchronous, active-high
  input  logic                      clr,
  input  logic                      mul_done,
  input  logic signed [2*WIDTH-1:0] mul_m,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   acc_out,
  output logic                      ovf,
  output logic                      drop_err,
  output logic [CNT_W-1:0]          cnt
);

  logic done_pulse;

  booth_done_edge u_done_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .done_i  (mul_done),
    .pulse_o (done_pulse)
  );

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      drop_q, drop_d;
  logic                      skid_full_q, skid_full_d;
  logic signed [2*WIDTH-1:0] skid_q, skid_d;

  logic signed [2*WIDTH-1:0] add_src;
  logic signed [ACC_W-1:0]   add_ext;
  logic signed [ACC_W-1:0]   add_raw;
  logic signed [ACC_W-1:0]   add_res;
  logic                      add_ovf;
  logic [CNT_W-1:0]          cnt_inc;

`ifdef BOOTH_DOT_ACC_SAT_EN
  logic signed [63:0]        sat_wide;
`endif

  // Adder datapath. A waiting skid entry always takes precedence over a
  // live product.
  always_comb begin
    add_src = skid_full_q ? skid_q : mul_m;
    add_ext = ACC_W'(add_src);
    add_raw = acc_q + add_ext;
    add_ovf = (acc_q[ACC_W-1] == add_ext[ACC_W-1]) &&
              (add_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef BOOTH_DOT_ACC_SAT_EN
    sat_wide = sat_add(64'(acc_q), 64'(add_ext), ACC_W);
    add_res  = sat_wide[ACC_W-1:0];
`else
    add_res  = add_raw;
`endif
    cnt_inc = cnt_q + CNT_W'(1);
  end

  // Next-state logic: accumulate, complete a sum, hold it, and manage the skid.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    skid_full_d = skid_full_q;
    skid_d      = skid_q;

    if (clr) begin
      state_d     = ACC;
      acc_d       = '0;
      acc_out_d   = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      drop_d      = 1'b0;
      skid_full_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (skid_full_q || done_pulse) begin
            // The first add of a sum starts a fresh overflow flag. Later
            // adds in the same sum keep the flag set once it is set.
            ovf_d = ((cnt_q == '0) ? 1'b0 : ovf_q) | add_ovf;
            if (cnt_inc == CNT_W'(LEN)) begin
              acc_out_d = add_res;
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = HOLD;
            end else begin
              acc_d = add_res;
              cnt_d = cnt_inc;
            end
          end
          // When the skid entry is consumed, a product arriving in the same
          // cycle takes its place.
          if (skid_full_q) begin
            skid_full_d = done_pulse;
            if (done_pulse) begin
              skid_d = mul_m;
            end
          end
        end
        HOLD: begin
          if (done_pulse) begin
            if (skid_full_q) begin
              drop_d = 1'b1;
            end else begin
              skid_full_d = 1'b1;
              skid_d      = mul_m;
            end
          end
          if (out_ready) begin
            state_d = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State registers. An asynchronous reset discards any partial or held sum.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      acc_out_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;
  assign drop_err  = drop_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_booth_dot_acc.sv
// Directed bench for booth_dot_acc.
// Instance A uses the default parameters. Instance B uses GUARD=0
// (ACC_W=16) so that overflow can be reached.
module tb_booth_dot_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic               clr_a = 1'b0, done_a = 1'b0, ready_a = 1'b0;
  logic signed [15:0] m_a = '0;
  logic               valid_a, ovf_a, drop_a;
  logic signed [23:0] acc_out_a;
  logic [2:0]         cnt_a;

  logic               clr_b = 1'b0, done_b = 1'b0, ready_b = 1'b0;
  logic signed [15:0] m_b = '0;
  logic               valid_b, ovf_b, drop_b;
  logic signed [15:0] acc_out_b;
  logic [2:0]         cnt_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  booth_dot_acc #(.WIDTH(8), .LEN(4), .GUARD(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .mul_done(done_a), .mul_m(m_a),
    .out_valid(valid_a), .out_ready(ready_a), .acc_out(acc_out_a),
    .ovf(ovf_a), .drop_err(drop_a), .cnt(cnt_a)
  );

  booth_dot_acc #(.WIDTH(8), .LEN(4), .GUARD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .mul_done(done_b), .mul_m(m_b),
    .out_valid(valid_b), .out_ready(ready_b), .acc_out(acc_out_b),
    .ovf(ovf_b), .drop_err(drop_b), .cnt(cnt_b)
  );

  typedef struct {
    int p0;
    int p1;
    int p2;
    int p3;
    int exp_sum;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) begin
      passed++;
      $display("check %-22s act=%0d exp=%0d ok", name, act, exp);
    end else begin
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One product: done rises for one cycle, then falls.
  task automatic prod(input bit sel, input int v);
    @(negedge clk);
    if (sel) begin
      done_b = 1'b1;
      m_b = 16'(v);
    end else begin
      done_a = 1'b1;
      m_a = 16'(v);
    end
    @(negedge clk);
    done_a = 1'b0;
    done_b = 1'b0;
  endtask

  // One output handshake; out_valid must be low afterwards.
  task automatic hs(input bit sel, input string name);
    @(negedge clk);
    if (sel) ready_b = 1'b1; else ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    ready_b = 1'b0;
    check(name, sel ? longint'(valid_b) : longint'(valid_a), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{p0: 1,      p1: -1,    p2: 1,      p3: 1000,  exp_sum: 1001};
    tbl[1] = '{p0: 16384,  p1: 16384, p2: 16384,  p3: 16384, exp_sum: 65536};
    tbl[2] = '{p0: -16256, p1: -16256, p2: -16256, p3: -16256, exp_sum: -65024};
    tbl[3] = '{p0: 127,    p1: -128,  p2: 0,      p3: 5,     exp_sum: 4};
    tbl[4] = '{p0: -16256, p1: 16384, p2: -16256, p3: 16384, exp_sum: 256};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", valid_a, 0);
    check("rst_acc_out", acc_out_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_drop", drop_a, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Table: complete dot products with sum, count and latency checks
    for (int i = 0; i < 5; i++) begin
      prod(0, tbl[i].p0);
      prod(0, tbl[i].p1);
      prod(0, tbl[i].p2);
      check($sformatf("v%0d_cnt3", i), cnt_a, 3);
      check($sformatf("v%0d_valid_early", i), valid_a, 0);
      prod(0, tbl[i].p3);
      check($sformatf("v%0d_valid", i), valid_a, 1);
      check($sformatf("v%0d_sum", i), acc_out_a, tbl[i].exp_sum);
      check($sformatf("v%0d_cnt0", i), cnt_a, 0);
      check($sformatf("v%0d_ovf", i), ovf_a, 0);
      hs(0, $sformatf("v%0d_hs", i));
    end

    // Held done counts once
    @(negedge clk);
    done_a = 1'b1;
    m_a = -16'sd50;
    repeat (5) @(negedge clk);
    done_a = 1'b0;
    check("held_done_cnt", cnt_a, 1);
    prod(0, 10);
    prod(0, 20);
    prod(0, 30);
    check("held_done_sum", acc_out_a, 10);
    hs(0, "held_done_hs");

    // Skid: one product during stall kept
    prod(0, 1); prod(0, 2); prod(0, 3); prod(0, 4);
    check("skid_sum10", acc_out_a, 10);
    prod(0, 40);
    check("skid_hold_valid", valid_a, 1);
    check("skid_hold_sum", acc_out_a, 10);
    check("skid_drop0", drop_a, 0);
    hs(0, "skid_hs1");
    @(negedge clk);
    check("skid_consumed_cnt", cnt_a, 1);
    prod(0, 1); prod(0, 1); prod(0, 1);
    check("skid_sum43", acc_out_a, 43);
    check("skid_drop_still0", drop_a, 0);
    // Two products during stall: second lost
    prod(0, 5);
    prod(0, 6);
    check("drop_err_set", drop_a, 1);
    check("drop_hold_sum", acc_out_a, 43);
    hs(0, "drop_hs");
    @(negedge clk);
    check("drop_skid_cnt", cnt_a, 1);
    prod(0, 1); prod(0, 1); prod(0, 1);
    check("drop_sum8", acc_out_a, 8);
    hs(0, "drop_hs2");

    // clr mid-sum, with a coincident event discarded
    prod(0, -16256);
    prod(0, 12700);
    check("clr_pre_cnt", cnt_a, 2);
    @(negedge clk);
    clr_a = 1'b1;
    done_a = 1'b1;
    m_a = 16'sd99;
    @(negedge clk);
    clr_a = 1'b0;
    done_a = 1'b0;
    check("clr_cnt", cnt_a, 0);
    check("clr_drop", drop_a, 0);
    check("clr_ovf", ovf_a, 0);
    check("clr_valid", valid_a, 0);
    prod(0, 1); prod(0, 1); prod(0, 1); prod(0, 1);
    check("clr_sum4", acc_out_a, 4);
    hs(0, "clr_hs");

    // Overflow with ACC_W=16
    prod(1, 16384);
    prod(1, 16384);
    check("ovf_mid", ovf_b, 1);
    prod(1, 16384);
    prod(1, 16384);
    check("ovf_valid", valid_b, 1);
    check("ovf_flag", ovf_b, 1);
`ifdef BOOTH_DOT_ACC_SAT_EN
    check("ovf_sat_sum", acc_out_b, 32767);
`else
    check("ovf_wrap_sum", acc_out_b, 0);
`endif
    hs(1, "ovf_hs");
    prod(1, 1);
    check("ovf_cleared_next", ovf_b, 0);
    prod(1, 1); prod(1, 1); prod(1, 1);
    check("ovf_next_sum", acc_out_b, 4);
    check("ovf_next_flag", ovf_b, 0);
    hs(1, "ovf_hs2");

    // Async reset mid-HOLD
    prod(0, 7); prod(0, 7); prod(0, 7); prod(0, 7);
    check("arst_pre_valid", valid_a, 1);
    check("arst_pre_sum", acc_out_a, 28);
    #2;
    rst_n = 1'b1;
    #1;
    check("arst_valid_now", valid_a, 0);
    check("arst_acc_now", acc_out_a, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_post_valid", valid_a, 0);
    check("arst_post_cnt", cnt_a, 0);
    check("arst_post_acc", acc_out_a, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
